// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one DDR2 command port between the D-cache (port 0) and the
// I-cache (port 1). One transaction is outstanding at a time. Each transaction is followed by
// one GAP cycle with no grant, which gives the requester a cycle to drop or update its valid.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN enables a 16-bit busy-state watchdog. When it
// fires, it sets err_timeout, pulses the owner's ready with rd_data = 0 and abandons the
// command. Without the macro, err_timeout is tied 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/rw/addr/wdata0 port 0 (D-cache) command; valid held until ready0
//   req_valid/rw/addr/wdata1 port 1 (I-cache) command; valid held until ready1
//   ready0, ready1           one-cycle completion pulse to the owning port
//   rd_data                  read data, broadcast to both ports
//   mem_valid/rw/addr/wdata  command to the memory controller
//   mem_rd_data, mem_ready   read data and one-cycle completion pulse from memory
//   grant                    one-hot current owner, 00 when idle
//   err_proto, err_timeout   sticky error flags
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 28,
    parameter int unsigned DATA_W         = 32,
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid0,
    input  logic              req_rw0,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [DATA_W-1:0] req_wdata0,
    output logic              ready0,
    input  logic              req_valid1,
    input  logic              req_rw1,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic              ready1,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              err_proto,
    output logic              err_timeout
);

    typedef enum logic [1:0] {StIdle, StBusy0, StBusy1, StGap} state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;              // 0: port 0 preferred on contention
    logic [1:0]        grant_q, grant_d;
    logic              mem_valid_q, mem_valid_d;
    logic              err_proto_q, err_proto_d;
    // Last command seen from the owner, replayed if the owner drops valid early.
    logic              hold_rw_q, hold_rw_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;

    logic              busy;
    logic              owner;
    logic              owner_valid;
    logic              owner_rw;
    logic [ADDR_W-1:0] owner_addr;
    logic [DATA_W-1:0] owner_wdata;
    logic              pick1;
    logic              timeout_fire;
    logic              done;

    always_comb begin
        busy        = (state_q == StBusy0) || (state_q == StBusy1);
        owner       = (state_q == StBusy1);
        owner_valid = owner ? req_valid1 : req_valid0;
        owner_rw    = owner ? req_rw1    : req_rw0;
        owner_addr  = owner ? req_addr1  : req_addr0;
        owner_wdata = owner ? req_wdata1 : req_wdata0;
        // Port 1 wins alone, or on contention in round-robin mode when the pointer says so.
        pick1       = req_valid1 && (!req_valid0 || (!FIXED_PRIO && rr_q));
        done        = busy && (mem_ready || timeout_fire);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        err_timeout_q, err_timeout_d;

    always_comb begin
        // Held at 0 outside BUSYn, so the first busy cycle always starts from 0.
        wd_d          = busy ? wd_q + 16'd1 : 16'd0;
        timeout_fire  = busy && !mem_ready && (wd_q == 16'(TIMEOUT_CYCLES - 1));
        err_timeout_d = err_timeout_q || timeout_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q          <= 16'd0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_fire = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        mem_valid_d  = mem_valid_q;
        err_proto_d  = err_proto_q;
        hold_rw_d    = hold_rw_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_ready) begin
                    err_proto_d = 1'b1;
                end
                if (req_valid0 || req_valid1) begin
                    state_d      = pick1 ? StBusy1 : StBusy0;
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    mem_valid_d  = 1'b1;
                    rr_d         = !pick1;
                    hold_rw_d    = pick1 ? req_rw1    : req_rw0;
                    hold_addr_d  = pick1 ? req_addr1  : req_addr0;
                    hold_wdata_d = pick1 ? req_wdata1 : req_wdata0;
                end
            end
            StBusy0, StBusy1: begin
                if (owner_valid) begin
                    hold_rw_d    = owner_rw;
                    hold_addr_d  = owner_addr;
                    hold_wdata_d = owner_wdata;
                end else begin
                    err_proto_d = 1'b1;
                end
                if (done) begin
                    state_d     = StGap;
                    grant_d     = 2'b00;
                    mem_valid_d = 1'b0;
                end
            end
            StGap: begin
                if (mem_ready) begin
                    err_proto_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_q         <= 1'b0;
            grant_q      <= 2'b00;
            mem_valid_q  <= 1'b0;
            err_proto_q  <= 1'b0;
            hold_rw_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            mem_valid_q  <= mem_valid_d;
            err_proto_q  <= err_proto_d;
            hold_rw_q    <= hold_rw_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

    // Command mux: live inputs while the owner holds valid, replayed values after it drops.
    always_comb begin
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (busy) begin
            if (owner_valid) begin
                mem_rw    = owner_rw;
                mem_addr  = owner_addr;
                mem_wdata = owner_wdata;
            end else begin
                mem_rw    = hold_rw_q;
                mem_addr  = hold_addr_q;
                mem_wdata = hold_wdata_q;
            end
        end
    end

    assign ready0    = done && grant_q[0];
    assign ready1    = done && grant_q[1];
    assign rd_data   = timeout_fire ? '0 : mem_rd_data;
    assign mem_valid = mem_valid_q;
    assign grant     = grant_q;
    assign err_proto = err_proto_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: round-robin instance, index 1: fixed-priority instance.
    logic          v0[2], rw0[2], v1[2], rw1[2], mrdy[2];
    logic [AW-1:0] a0[2], a1[2], ma[2];
    logic [DW-1:0] d0[2], d1[2], mrd[2], rd[2], mwd[2];
    logic          r0[2], r1[2], mv[2], mrw[2], ep[2], et[2];
    logic [1:0]    gnt[2];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(16)) u_dut_rr (
        .clk(clk), .rst(rst),
        .req_valid0(v0[0]), .req_rw0(rw0[0]), .req_addr0(a0[0]), .req_wdata0(d0[0]),
        .ready0(r0[0]),
        .req_valid1(v1[0]), .req_rw1(rw1[0]), .req_addr1(a1[0]), .req_wdata1(d1[0]),
        .ready1(r1[0]),
        .rd_data(rd[0]), .mem_valid(mv[0]), .mem_rw(mrw[0]), .mem_addr(ma[0]),
        .mem_wdata(mwd[0]), .mem_rd_data(mrd[0]), .mem_ready(mrdy[0]), .grant(gnt[0]),
        .err_proto(ep[0]), .err_timeout(et[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(16)) u_dut_fp (
        .clk(clk), .rst(rst),
        .req_valid0(v0[1]), .req_rw0(rw0[1]), .req_addr0(a0[1]), .req_wdata0(d0[1]),
        .ready0(r0[1]),
        .req_valid1(v1[1]), .req_rw1(rw1[1]), .req_addr1(a1[1]), .req_wdata1(d1[1]),
        .ready1(r1[1]),
        .rd_data(rd[1]), .mem_valid(mv[1]), .mem_rw(mrw[1]), .mem_addr(ma[1]),
        .mem_wdata(mwd[1]), .mem_rd_data(mrd[1]), .mem_ready(mrdy[1]), .grant(gnt[1]),
        .err_proto(ep[1]), .err_timeout(et[1])
    );

    typedef struct {
        int            dut;
        logic          port;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic p, input logic rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (p) begin
            v1[d] = 1'b1; rw1[d] = rw; a1[d] = addr; d1[d] = wdata;
        end else begin
            v0[d] = 1'b1; rw0[d] = rw; a0[d] = addr; d0[d] = wdata;
        end
    endtask

    task automatic expect_txn(input int d, input logic p, input logic rw,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] rdata);
        exp_t e;
        e.dut = d; e.port = p; e.rw = rw; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sb.push_back(e);
    endtask

    task automatic req(input int d, input logic p, input logic rw, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        drive(d, p, rw, addr, wdata);
        expect_txn(d, p, rw, addr, wdata, rdata);
    endtask

    task automatic drop(input int d, input logic p);
        if (p) v1[d] = 1'b0;
        else   v0[d] = 1'b0;
    endtask

    // Waits (bounded) for mem_valid, returning at a falling edge with it high.
    task automatic wait_mv(input int d, output int waited);
        waited = 0;
        @(negedge clk);
        while (mv[d] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mem_valid_seen", mv[d], 1'b1);
    endtask

    // Pops the next expected transaction, checks the command, answers after lat busy cycles.
    task automatic serve(input int lat, output int waited);
        exp_t e;
        waited = 0;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected a transaction");
            return;
        end
        e = sb.pop_front();
        wait_mv(e.dut, waited);
        chk("grant", gnt[e.dut], e.port ? 2'b10 : 2'b01);
        chk("mem_rw", mrw[e.dut], e.rw);
        chk("mem_addr", ma[e.dut], e.addr);
        chk("mem_wdata", mwd[e.dut], e.wdata);
        repeat (lat - 1) @(negedge clk);
        mrdy[e.dut] = 1'b1;
        mrd[e.dut]  = e.rdata;
        #1;
        chk("ready_owner", e.port ? r1[e.dut] : r0[e.dut], 1'b1);
        chk("ready_other", e.port ? r0[e.dut] : r1[e.dut], 1'b0);
        chk("rd_data", rd[e.dut], e.rdata);
        @(posedge clk);
        #1;
        mrdy[e.dut] = 1'b0;
        mrd[e.dut]  = '0;
        drop(e.dut, e.port);
        @(negedge clk);
        chk("gap_grant", gnt[e.dut], 2'b00);
        chk("gap_mem_valid", mv[e.dut], 1'b0);
        chk("gap_ready", {r0[e.dut], r1[e.dut]}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int w;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            v0[i] = 0; rw0[i] = 0; a0[i] = '0; d0[i] = '0;
            v1[i] = 0; rw1[i] = 0; a1[i] = '0; d1[i] = '0;
            mrdy[i] = 0; mrd[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", gnt[0], 2'b00);
        chk("rst_mem_valid", mv[0], 1'b0);
        chk("rst_mem_rw", mrw[0], 1'b0);
        chk("rst_err_proto", ep[0], 1'b0);
        chk("rst_err_timeout", et[0], 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention, round-robin: expected order p0, p1, p0, p1.
        req(0, 1'b0, 1'b1, 28'h0000100, 32'hA0000000, 32'h11111111);
        req(0, 1'b1, 1'b0, 28'h0000200, 32'hB0000000, 32'h22222222);
        serve(2, w);
        req(0, 1'b0, 1'b0, 28'h0000101, 32'hA0000001, 32'h33333333);
        serve(2, w);
        req(0, 1'b1, 1'b1, 28'h0000201, 32'hB0000001, 32'h44444444);
        serve(3, w);
        serve(1, w);

        // Port 1 read.
        @(posedge clk);
        #1 req(0, 1'b1, 1'b0, 28'h1000009, 32'h0, 32'h010BBBBB);
        serve(2, w);

        // Port 0 write: mem_valid appears one cycle after valid is sampled.
        @(posedge clk);
        #1 req(0, 1'b0, 1'b1, 28'h0000008, 32'h010000FF, 32'h0);
        @(negedge clk);
        chk("mv_before_grant", mv[0], 1'b0);
        serve(3, w);
        chk("grant_latency", w, 0);

        // mem_ready while idle is ignored and flagged.
        chk("err_proto_clean", ep[0], 1'b0);
        @(negedge clk);
        mrdy[0] = 1'b1;
        mrd[0]  = 32'h55555555;
        #1;
        chk("idle_ready", {r0[0], r1[0]}, 2'b00);
        @(posedge clk);
        #1 mrdy[0] = 1'b0;
        @(negedge clk);
        chk("idle_ready_err", ep[0], 1'b1);

        // Reset mid-transaction drops mem_valid and clears flags.
        drive(0, 1'b1, 1'b0, 28'h0000ABC, 32'h0);
        wait_mv(0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drop(0, 1'b1);
        @(negedge clk);
        chk("midrst_mem_valid", mv[0], 1'b0);
        chk("midrst_grant", gnt[0], 2'b00);
        chk("midrst_err_proto", ep[0], 1'b0);

        // After reset the pointer prefers port 0 again.
        @(posedge clk);
        #1;
        req(0, 1'b0, 1'b0, 28'h0000300, 32'h0, 32'h66666666);
        req(0, 1'b1, 1'b0, 28'h0000400, 32'h0, 32'h77777777);
        serve(2, w);
        serve(2, w);

        // Owner drops valid early: error flagged, command replayed until mem_ready.
        @(posedge clk);
        #1 req(0, 1'b0, 1'b1, 28'h0000555, 32'hCAFE0001, 32'h88888888);
        e = sb.pop_front();
        wait_mv(0, w);
        drop(0, 1'b0);
        a0[0] = 28'h0FFFFFF;
        d0[0] = 32'hFFFFFFFF;
        #1;
        chk("held_addr", ma[0], e.addr);
        chk("held_wdata", mwd[0], e.wdata);
        chk("held_rw", mrw[0], e.rw);
        @(negedge clk);
        chk("drop_mem_valid", mv[0], 1'b1);
        chk("drop_err_proto", ep[0], 1'b1);
        mrdy[0] = 1'b1;
        mrd[0]  = e.rdata;
        #1;
        chk("drop_ready0", r0[0], 1'b1);
        chk("drop_rd_data", rd[0], e.rdata);
        @(posedge clk);
        #1 mrdy[0] = 1'b0;
        @(negedge clk);
        chk("drop_gap_mv", mv[0], 1'b0);

        // Fixed priority: port 0 wins every time while port 1 waits.
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b0, 28'h0000900, 32'h0);
        req(1, 1'b0, 1'b1, 28'h0000800, 32'hD0000000, 32'h0);
        serve(2, w);
        req(1, 1'b0, 1'b1, 28'h0000801, 32'hD0000001, 32'h0);
        serve(2, w);
        req(1, 1'b0, 1'b0, 28'h0000802, 32'h0, 32'h99999999);
        serve(1, w);
        expect_txn(1, 1'b1, 1'b0, 28'h0000900, 32'h0, 32'hAAAAAAAA);
        serve(2, w);

`ifdef MEM_ARB_TIMEOUT_EN
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 28'h0000777, 32'h0);
        mrd[0] = 32'hDEADBEEF;
        wait_mv(0, w);
        repeat (14) @(negedge clk);
        chk("pre_timeout_ready", r0[0], 1'b0);
        @(negedge clk);
        chk("timeout_ready", r0[0], 1'b1);
        chk("timeout_rd_data", rd[0], 32'h0);
        @(posedge clk);
        #1 drop(0, 1'b0);
        @(negedge clk);
        chk("timeout_mv", mv[0], 1'b0);
        chk("timeout_err", et[0], 1'b1);
`else
        chk("no_timeout_err", et[0], 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
